ser_tx4: RTL and testbench

- Parallel-in, serial-out frame transmitter.
- Captures a WIDTH-bit word (default 4) on a load strobe and shifts it onto a single serial line, MSB first, framed by a start bit (0) and a stop bit (1).
- Is the sending end of the serial link whose receiving end assembles words back into the 4-bit register file.
- Supports a Hold input that freezes all progress.

---
 rtl/ser_tx4_if.sv | 22 ++
 rtl/ser_tx4.sv | 121 ++++++++++++
 tb/tb_ser_tx4.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ser_tx4_if.sv
// Bundle between a frame source and the ser_tx4 transmitter.
// Signal prefixes are from the transmitter's point of view.
interface ser_tx4_if #(
  parameter int unsigned WIDTH = 4
);
  logic             i_load;
  logic             i_hold;
  logic [WIDTH-1:0] i_data;
  logic             o_tx;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_load, i_hold, i_data,
    input  o_tx, o_busy, o_done
  );

  modport slave (
    input  i_load, i_hold, i_data,
    output o_tx, o_busy, o_done
  );
endinterface

// File: rtl/ser_tx4.sv
// Parallel-in, serial-out frame transmitter: start bit (0), WIDTH data bits MSB first,
// stop bit (1), each bit BAUD_DIV clocks long. Hold freezes all progress.
module ser_tx4 #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned BAUD_DIV = 1
) (
  input logic       i_clk,
  input logic       i_rst_n,
  ser_tx4_if.slave  io_bus
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [7:0] DivMax = 8'(BAUD_DIV - 1);
  localparam logic [3:0] CntMax = 4'(WIDTH - 1);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic [7:0]       r_div, w_div_d;
  logic [3:0]       r_cnt, w_cnt_d;
  logic             r_tx, r_busy, r_done;
  logic             w_tx_d, w_busy_d, w_done_d;
  logic             w_bound;

  assign w_bound = (r_div == DivMax);

  // State register; reset overrides Hold and abandons any frame in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; Hold keeps the current state.
  always_comb begin
    w_state_d = r_state;
    if (!io_bus.i_hold) begin
      unique case (r_state)
        StIdle:  if (io_bus.i_load) w_state_d = StStart;
        StStart: if (w_bound) w_state_d = StData;
        StData:  if (w_bound && (r_cnt == CntMax)) w_state_d = StStop;
        StStop:  if (w_bound) w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Datapath next values: shift register, bit divider and bit counter.
  always_comb begin
    w_shift_d = r_shift;
    w_div_d   = r_div;
    w_cnt_d   = r_cnt;
    if (!io_bus.i_hold) begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.i_load) begin
            w_shift_d = io_bus.i_data;
            w_div_d   = '0;
            w_cnt_d   = '0;
          end
        end
        StData: begin
          if (w_bound) begin
            w_div_d   = '0;
            w_shift_d = r_shift << 1;
            w_cnt_d   = r_cnt + 4'd1;
          end else begin
            w_div_d = r_div + 8'd1;
          end
        end
        default: begin
          // Start and stop bits only time out; counter restarts for the data phase.
          if (w_bound) begin
            w_div_d = '0;
            w_cnt_d = '0;
          end else begin
            w_div_d = r_div + 8'd1;
          end
        end
      endcase
    end
  end

  // Registered outputs derived from the state being entered.
  always_comb begin
    w_tx_d   = 1'b1;
    w_busy_d = (w_state_d != StIdle);
    w_done_d = (r_state == StStop) && (w_state_d == StIdle);
    unique case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_shift_d[WIDTH-1];
      default: w_tx_d = 1'b1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_shift <= w_shift_d;
      r_div   <= w_div_d;
      r_cnt   <= w_cnt_d;
      r_tx    <= w_tx_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign io_bus.o_tx   = r_tx;
  assign io_bus.o_busy = r_busy;
  assign io_bus.o_done = r_done;

endmodule

// File: tb/tb_ser_tx4.sv
// Directed bench for ser_tx4: one instance with BAUD_DIV=1, one with BAUD_DIV=3.
module tb_ser_tx4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ser_tx4_if #(.WIDTH(4)) bus1 ();
  ser_tx4_if #(.WIDTH(4)) bus3 ();

  ser_tx4 #(.WIDTH(4), .BAUD_DIV(1)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus1)
  );

  ser_tx4 #(.WIDTH(4), .BAUD_DIV(3)) dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // sel=0 checks the BAUD_DIV=1 instance, sel=1 the BAUD_DIV=3 instance.
  task automatic chk_out(input string tag, input bit sel, input logic etx, input logic ebusy,
                         input logic edone);
    if (!sel) begin
      chk($sformatf("%s.tx", tag), bus1.o_tx, etx);
      chk($sformatf("%s.busy", tag), bus1.o_busy, ebusy);
      chk($sformatf("%s.done", tag), bus1.o_done, edone);
    end else begin
      chk($sformatf("%s.tx", tag), bus3.o_tx, etx);
      chk($sformatf("%s.busy", tag), bus3.o_busy, ebusy);
      chk($sformatf("%s.done", tag), bus3.o_done, edone);
    end
  endtask

  initial begin
    logic [5:0]  pat6;
    logic [9:0]  pat10;
    n_cmp = 0;
    n_err = 0;

    // Reset with Load high and all-ones data: nothing may start.
    rst_n = 1'b0;
    bus1.i_load = 1'b1; bus1.i_hold = 1'b0; bus1.i_data = 4'hF;
    bus3.i_load = 1'b1; bus3.i_hold = 1'b0; bus3.i_data = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out($sformatf("rst%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
      chk_out($sformatf("rst3_%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    bus1.i_load = 1'b0;
    bus3.i_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out($sformatf("post_rst%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Single frame 1010: start, 1,0,1,0, stop.
    bus1.i_load = 1'b1; bus1.i_data = 4'b1010;
    pat6 = 6'b010101;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) begin
        bus1.i_load = 1'b0;
        bus1.i_data = 4'h5;
      end
      chk_out($sformatf("single%0d", i), 1'b0, pat6[5-i], 1'b1, 1'b0);
    end
    tick();
    chk_out("single_done", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("single_after", 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back: 0x3 then 0xC with Load held high through the first frame.
    bus1.i_load = 1'b1; bus1.i_data = 4'h3;
    pat6 = 6'b000111;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus1.i_data = 4'hC;
      chk_out($sformatf("b2b_a%0d", i), 1'b0, pat6[5-i], 1'b1, 1'b0);
    end
    tick();
    chk_out("b2b_gap", 1'b0, 1'b1, 1'b0, 1'b1);
    pat6 = 6'b011001;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus1.i_load = 1'b0;
      chk_out($sformatf("b2b_b%0d", i), 1'b0, pat6[5-i], 1'b1, 1'b0);
    end
    tick();
    chk_out("b2b_done", 1'b0, 1'b1, 1'b0, 1'b1);

    // Divider: BAUD_DIV=3, data 0001, each level three cycles.
    bus3.i_load = 1'b1; bus3.i_data = 4'b0001;
    pat6 = 6'b000011;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 0) bus3.i_load = 1'b0;
      chk_out($sformatf("div%0d", i), 1'b1, pat6[5-(i/3)], 1'b1, 1'b0);
    end
    tick();
    chk_out("div_done", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("div_after", 1'b1, 1'b1, 1'b0, 1'b0);

    // Load while Hold is high in idle must not start a frame.
    bus1.i_load = 1'b1; bus1.i_hold = 1'b1; bus1.i_data = 4'hF;
    tick();
    chk_out("hold_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    bus1.i_load = 1'b0; bus1.i_hold = 1'b0;
    tick();
    chk_out("hold_idle_after", 1'b0, 1'b1, 1'b0, 1'b0);

    // Hold for 4 cycles during the second data bit of 1100.
    bus1.i_load = 1'b1; bus1.i_data = 4'b1100;
    pat10 = 10'b0111111001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) bus1.i_load = 1'b0;
      if (i == 2) bus1.i_hold = 1'b1;
      if (i == 6) bus1.i_hold = 1'b0;
      chk_out($sformatf("hold%0d", i), 1'b0, pat10[9-i], 1'b1, 1'b0);
    end
    tick();
    chk_out("hold_done", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("hold_after", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset during the third data bit of 1010 abandons the frame silently.
    bus1.i_load = 1'b1; bus1.i_data = 4'b1010;
    pat6 = 6'b010101;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) bus1.i_load = 1'b0;
      chk_out($sformatf("mid%0d", i), 1'b0, pat6[5-i], 1'b1, 1'b0);
    end
    rst_n = 1'b0;
    tick();
    chk_out("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("mid_idle%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Fresh frame 0110 after the abandoned one.
    bus1.i_load = 1'b1; bus1.i_data = 4'b0110;
    pat6 = 6'b001101;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus1.i_load = 1'b0;
      chk_out($sformatf("redo%0d", i), 1'b0, pat6[5-i], 1'b1, 1'b0);
    end
    tick();
    chk_out("redo_done", 1'b0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
